// File: rtl/ff_array_2p_be.sv
// Flip-flop metadata array: port 0 read/write with lane mask, port 1 read-only, flush sequencer.
// Optional macro FF_ARRAY_BYPASS_EN forwards a pending port-0 write to dout1 on matching sets.
module ff_array_2p_be #(
  parameter int S_INDEX    = 4,
  parameter int WIDTH      = 32,
  parameter int LANE_W     = 8,
  parameter int FLUSH_ROWS = 1
) (
  input  logic                        clk0,
  input  logic                        rst0,
  input  logic                        csb0,
  input  logic                        web0,
  input  logic [WIDTH/LANE_W-1:0]     wmask0,
  input  logic [S_INDEX-1:0]          addr0,
  input  logic [WIDTH-1:0]            din0,
  output logic [WIDTH-1:0]            dout0,
  input  logic                        csb1,
  input  logic [S_INDEX-1:0]          addr1,
  output logic [WIDTH-1:0]            dout1,
  input  logic                        flush_req,
  output logic                        flush_busy
);

  localparam int NUM_SETS  = 2 ** S_INDEX;
  localparam int NUM_LANES = WIDTH / LANE_W;
  localparam int GROUPS    = NUM_SETS / FLUSH_ROWS;
  localparam int CNT_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_mem [NUM_SETS];
  logic [S_INDEX-1:0]     r_addr0;
  logic [S_INDEX-1:0]     r_addr1;
  logic [NUM_LANES-1:0]   r_wmask0;
  logic [WIDTH-1:0]       r_din0;
  logic                   r_wvalid;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_last;
  logic                   w_accept0;
  logic                   w_accept1;
  logic                   w_flushing;

  assign w_last = (r_cnt == CNT_W'(GROUPS - 1));

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (flush_req) w_state_nxt = FLUSH;
      FLUSH:   if (w_last)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A flush request in IDLE takes priority over both ports' requests that cycle.
  always_comb begin
    w_flushing = (r_state == FLUSH);
    flush_busy = w_flushing;
    w_accept0  = (r_state == IDLE) && !flush_req && !csb0;
    w_accept1  = (r_state == IDLE) && !flush_req && !csb1;
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_wmask0 <= '0;
      r_din0   <= '0;
      r_wvalid <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_wvalid <= w_accept0 && !web0;
      if (w_accept0) begin
        r_addr0  <= addr0;
        r_wmask0 <= wmask0;
        r_din0   <= din0;
      end
      if (w_accept1) r_addr1 <= addr1;
      if (w_flushing) r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // No write can be pending while flushing: the flush-start edge never captures one.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) r_mem[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        if (w_flushing && (CNT_W'(s / FLUSH_ROWS) == r_cnt)) begin
          r_mem[s] <= '0;
        end else if (r_wvalid && (r_addr0 == S_INDEX'(s))) begin
          for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (r_wmask0[l]) r_mem[s][l*LANE_W +: LANE_W] <= r_din0[l*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

`ifdef FF_ARRAY_BYPASS_EN
  logic [WIDTH-1:0] w_merged;

  always_comb begin
    w_merged = r_mem[r_addr1];
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (r_wmask0[l]) w_merged[l*LANE_W +: LANE_W] = r_din0[l*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    dout0 = '0;
    dout1 = '0;
    if (!w_flushing) begin
      dout0 = r_mem[r_addr0];
      dout1 = (r_wvalid && (r_addr1 == r_addr0)) ? w_merged : r_mem[r_addr1];
    end
  end
`else
  always_comb begin
    dout0 = '0;
    dout1 = '0;
    if (!w_flushing) begin
      dout0 = r_mem[r_addr0];
      dout1 = r_mem[r_addr1];
    end
  end
`endif

endmodule

// File: tb/tb_ff_array_2p_be.sv
// Directed self-checking bench for ff_array_2p_be (S_INDEX=4, WIDTH=32, LANE_W=8, FLUSH_ROWS=4).
module tb_ff_array_2p_be;

  logic        clk0;
  logic        rst0;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [3:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        csb1;
  logic [3:0]  addr1;
  logic [31:0] dout1;
  logic        flush_req;
  logic        flush_busy;

  int unsigned n_checks;
  int unsigned n_errors;

  ff_array_2p_be #(
    .S_INDEX    (4),
    .WIDTH      (32),
    .LANE_W     (8),
    .FLUSH_ROWS (4)
  ) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .csb0       (csb0),
    .web0       (web0),
    .wmask0     (wmask0),
    .addr0      (addr0),
    .din0       (din0),
    .dout0      (dout0),
    .csb1       (csb1),
    .addr1      (addr1),
    .dout1      (dout1),
    .flush_req  (flush_req),
    .flush_busy (flush_busy)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0      = 1'b1;
    web0      = 1'b1;
    csb1      = 1'b1;
    flush_req = 1'b0;
    wmask0    = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0   = 1'b0;
    web0   = 1'b0;
    addr0  = a;
    din0   = d;
    wmask0 = m;
    tick();
    idle();
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    csb0  = 1'b0;
    web0  = 1'b1;
    addr0 = a0;
    csb1  = 1'b0;
    addr1 = a1;
    tick();
    idle();
  endtask

  initial begin
    logic [31:0] exp_bypass;
    n_checks = 0;
    n_errors = 0;
    rst0  = 1'b1;
    addr0 = '0;
    addr1 = '0;
    din0  = '0;
    idle();
    #1;
    check_eq("reset_dout0", dout0, 32'h0);
    check_eq("reset_dout1", dout1, 32'h0);
    check_eq("reset_busy", {31'h0, flush_busy}, 32'h0);
    @(negedge clk0);
    rst0 = 1'b0;

    // Masked write, back-to-back to the same set
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3, 4'd3);
    check_eq("masked_dout0", dout0, 32'hAA22CC44);
    check_eq("masked_dout1", dout1, 32'hAA22CC44);

    // Dual-port read of two different sets
    wr(4'd5, 32'h55555555, 4'b1111);
    wr(4'd9, 32'h99999999, 4'b1111);
    rd(4'd5, 4'd9);
    check_eq("dual_dout0", dout0, 32'h55555555);
    check_eq("dual_dout1", dout1, 32'h99999999);

    // Zero mask write is a no-op
    wr(4'd5, 32'hFFFFFFFF, 4'b0000);
    rd(4'd5, 4'd5);
    check_eq("nomask_dout0", dout0, 32'h55555555);

    // Read during write to set 2
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd2; din0 = 32'hFFFFFFFF; wmask0 = 4'b1111;
    csb1 = 1'b0; addr1 = 4'd2;
    tick();
    idle();
`ifdef FF_ARRAY_BYPASS_EN
    exp_bypass = 32'hFFFFFFFF;
`else
    exp_bypass = 32'h00000000;
`endif
    check_eq("rdw_t1_dout0", dout0, 32'h0);
    check_eq("rdw_t1_dout1", dout1, exp_bypass);
    tick();
    check_eq("rdw_t2_dout0", dout0, 32'hFFFFFFFF);
    check_eq("rdw_t2_dout1", dout1, 32'hFFFFFFFF);

    // Fill every set, then verify a couple
    for (int s = 0; s < 16; s++) wr(4'(s), {16'hA5A5, 16'(s)}, 4'b1111);
    rd(4'd0, 4'd15);
    check_eq("fill_dout0", dout0, 32'hA5A50000);
    check_eq("fill_dout1", dout1, 32'hA5A5000F);

    // Write captured the cycle before flush commits; write with flush_req is dropped
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3; din0 = 32'h0000DEAD; wmask0 = 4'b1111;
    tick();
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd7; din0 = 32'h00001234; wmask0 = 4'b1111;
    csb1 = 1'b0; addr1 = 4'd7; flush_req = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      check_eq("flush_busy_hi", {31'h0, flush_busy}, 32'h1);
      check_eq("flush_dout0", dout0, 32'h0);
      check_eq("flush_dout1", dout1, 32'h0);
      if (c < 2) begin
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd7; din0 = 32'h0000BEEF; wmask0 = 4'b1111;
        flush_req = 1'b1;
      end else begin
        idle();
      end
      tick();
    end
    check_eq("flush_busy_lo", {31'h0, flush_busy}, 32'h0);
    for (int s = 0; s < 16; s++) begin
      rd(4'(s), 4'(15 - s));
      check_eq("flushed_dout0", dout0, 32'h0);
      check_eq("flushed_dout1", dout1, 32'h0);
    end

    // Async reset in the second busy cycle
    wr(4'd4, 32'h44444444, 4'b1111);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check_eq("rst_busy_c1", {31'h0, flush_busy}, 32'h1);
    tick();
    #2;
    rst0 = 1'b1;
    #1;
    check_eq("rst_mid_busy", {31'h0, flush_busy}, 32'h0);
    check_eq("rst_mid_dout0", dout0, 32'h0);
    check_eq("rst_mid_dout1", dout1, 32'h0);
    @(negedge clk0);
    rst0 = 1'b0;
    wr(4'd6, 32'h66CC0011, 4'b1111);
    rd(4'd6, 4'd6);
    check_eq("post_rst_dout0", dout0, 32'h66CC0011);
    check_eq("post_rst_dout1", dout1, 32'h66CC0011);
    rd(4'd4, 4'd4);
    check_eq("post_rst_set4", dout0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
